// File: rtl/vga_word_queue_pkg.sv
// Shared definitions for the frame-paced display queue: register map,
// status/control bit positions, display FSM states and hold reload helper.
package vga_word_queue_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_HOLD   = 2'd2;
  localparam logic [1:0] REG_DIRECT = 2'd3;

  localparam int ST_EMPTY_BIT  = 0;
  localparam int ST_FULL_BIT   = 1;
  localparam int ST_OVF_BIT    = 2;
  localparam int ST_IRQ_EN_BIT = 3;

  localparam int CTL_CLR_OVF_BIT = 0;
  localparam int CTL_FLUSH_BIT   = 1;
  localparam int CTL_IRQ_EN_BIT  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } disp_state_t;

  // Frames left after a pop; a stored hold of 0 behaves like 1.
  function automatic logic [15:0] hold_reload(input logic [15:0] hold);
    return (hold == 16'd0) ? 16'd0 : hold - 16'd1;
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous FIFO with flush; flush takes precedence over pop, and a push
// in the flush cycle lands as the first entry of the emptied queue.
module word_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;
  logic [AW-1:0]    wr_idx;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & (flush_i | ~full_o | do_pop);
  assign wr_idx  = flush_i ? '0 : wptr_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = do_push ? AW'(1) : '0;
      count_d = do_push ? CW'(1) : '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx] <= wdata_i;
  end

endmodule

// File: rtl/vga_word_queue.sv
// Avalon-MM word queue feeding the seven-segment VGA emulator; words advance
// only on frame ticks. Define VGA_WORD_QUEUE_IRQ_EN to build the interrupt.
import vga_word_queue_pkg::*;

module vga_word_queue #(
  parameter int          DEPTH       = 8,
  parameter logic [15:0] HOLD_FRAMES = 16'd60
) (
  input  logic        clk50,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        frame_tick,
  output logic [31:0] data_out,
  output logic        irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_sel, rd_sel;
  logic          push, pop, flush, ctl_wr, direct_wr, hold_wr;
  logic [31:0]   head;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          irq_en;

  disp_state_t   state_q;
  logic [15:0]   frame_cnt_q;
  logic [15:0]   hold_q;
  logic          ovf_q;
  logic [31:0]   data_out_q;
  logic [31:0]   readdata_q, readdata_d;
  logic [31:0]   status;

  assign wr_sel    = chipselect & write;
  assign rd_sel    = chipselect & read;
  assign push      = wr_sel & (address == REG_DATA);
  assign ctl_wr    = wr_sel & (address == REG_STATUS);
  assign hold_wr   = wr_sel & (address == REG_HOLD);
  assign direct_wr = wr_sel & (address == REG_DIRECT);
  assign flush     = ctl_wr & writedata[CTL_FLUSH_BIT];
  // Pop decision uses the pre-edge count, so a same-cycle push is never bypassed.
  assign pop       = frame_tick & (state_q == IDLE) & ~empty & ~flush;

  word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk50),
    .rst_n   (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (writedata),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      data_out_q  <= '0;
    end else begin
      if (flush) begin
        state_q     <= IDLE;
        frame_cnt_q <= '0;
      end else if (pop) begin
        frame_cnt_q <= hold_reload(hold_q);
        state_q     <= (hold_reload(hold_q) != 16'd0) ? HOLD : IDLE;
      end else if (frame_tick && state_q == HOLD) begin
        frame_cnt_q <= frame_cnt_q - 16'd1;
        if (frame_cnt_q == 16'd1) state_q <= IDLE;
      end
      // A direct load wins over a coincident pop for the displayed word.
      if (direct_wr)  data_out_q <= writedata;
      else if (pop)   data_out_q <= head;
    end
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      hold_q     <= HOLD_FRAMES;
      ovf_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      if (hold_wr) hold_q <= writedata[15:0];
      if (push && full && !pop && !flush)        ovf_q <= 1'b1;
      else if (ctl_wr && writedata[CTL_CLR_OVF_BIT]) ovf_q <= 1'b0;
      if (rd_sel) readdata_q <= readdata_d;
    end
  end

`ifdef VGA_WORD_QUEUE_IRQ_EN
  logic irq_en_q, irq_q;

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (ctl_wr) irq_en_q <= writedata[CTL_IRQ_EN_BIT];
      irq_q <= irq_en_q & (empty | ovf_q);
    end
  end

  assign irq_en = irq_en_q;
  assign irq    = irq_q;
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  always_comb begin
    status                = '0;
    status[15:8]          = 8'(count);
    status[ST_IRQ_EN_BIT] = irq_en;
    status[ST_OVF_BIT]    = ovf_q;
    status[ST_FULL_BIT]   = full;
    status[ST_EMPTY_BIT]  = empty;
  end

  always_comb begin
    readdata_d = '0;
    unique case (address)
      REG_DATA:   readdata_d = data_out_q;
      REG_STATUS: readdata_d = status;
      REG_HOLD:   readdata_d = {16'b0, hold_q};
      REG_DIRECT: readdata_d = '0;
      default:    readdata_d = '0;
    endcase
  end

  assign data_out = data_out_q;
  assign readdata = readdata_q;

endmodule
